exer2_op_sequencer: RTL and testbench

- Front-panel controller that sequences the exercise-2 arithmetic/bit-count datapath from the Nexys A7 buttons and 16 slide switches.
- Selects the active test, captures operands from the switch register, issues a one-cycle start to the shared datapath, waits for its done handshake, and holds the result for the display.
- Sits between the board I/O and the datapath units: leading ones, number of ones, add, subtract and multiply.

---
 rtl/exer2_op_sequencer.sv | 148 ++++++++++++++
 tb/tb_exer2_op_sequencer.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/exer2_op_sequencer.sv
// Front-panel sequencer for the exercise-2 datapath: button decode, operand capture,
// start/done handshake and result hold. Optional WAIT timeout under `CTRL_TIMEOUT_EN`.
module exer2_op_sequencer #(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int TEST_INIT      = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  btn,
  input  logic [15:0] sw,
  input  logic        op_done,
  input  logic [15:0] op_result,
  output logic [2:0]  test_sel,
  output logic [7:0]  op_a,
  output logic [7:0]  op_b,
  output logic        op_start,
  output logic [15:0] result,
  output logic        result_valid,
  output logic        busy,
  output logic        err
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_CAPTURE} state_t;
  typedef enum logic [2:0] {A_NONE, A_C, A_U, A_D, A_L, A_R} action_t;

  state_t     state, state_nxt;
  action_t    action;
  logic [4:0] btn_s1, btn_s2, btn_prev;
  logic [4:0] press;
  logic       timeout;

  // Two-flop synchronizer plus edge detector: a held button yields a single press.
  // NOTE: sequential state always uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_s1   <= '0;
      btn_s2   <= '0;
      btn_prev <= '0;
    end else begin
      btn_s1   <= btn;
      btn_s2   <= btn_s1;
      btn_prev <= btn_s2;
    end
  end

  assign press = btn_s2 & ~btn_prev;

  // Fixed priority C > U > D > L > R; presses outside IDLE are dropped, not queued.
  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    action = A_NONE;
    if (state == S_IDLE) begin
      if      (press[4]) action = A_C;
      else if (press[3]) action = A_U;
      else if (press[2]) action = A_D;
      else if (press[1]) action = A_L;
      else if (press[0]) action = A_R;
    end
  end

`ifdef CTRL_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] to_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 to_cnt <= '0;
    else if (state == S_ISSUE)  to_cnt <= '0;
    else if (state == S_WAIT)   to_cnt <= to_cnt + 1'b1;
  end

  // Fires in the TIMEOUT_CYCLES-th WAIT cycle when no op_done has arrived.
  assign timeout = (state == S_WAIT) && !op_done && (to_cnt == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                err <= 1'b0;
    else if (timeout)          err <= 1'b1;
    else if (action == A_R)    err <= 1'b0;
  end
`else
  assign timeout = 1'b0;
  assign err     = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:    if (action == A_C) state_nxt = S_ISSUE;
      S_ISSUE:   state_nxt = S_WAIT;
      S_WAIT: begin
        if (op_done)      state_nxt = S_CAPTURE;
        else if (timeout) state_nxt = S_IDLE;
      end
      S_CAPTURE: state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    op_start = (state == S_ISSUE);
    busy     = (state == S_ISSUE) || (state == S_WAIT);
  end

  // Selection and operands only change on IDLE actions, so they stay frozen while busy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      test_sel     <= 3'(TEST_INIT);
      op_a         <= '0;
      op_b         <= '0;
      result       <= '0;
      result_valid <= 1'b0;
    end else begin
      unique case (action)
        A_U: begin
          test_sel     <= (test_sel == 3'd4) ? 3'd0 : test_sel + 3'd1;
          result_valid <= 1'b0;
        end
        A_D: begin
          test_sel     <= (test_sel == 3'd0) ? 3'd4 : test_sel - 3'd1;
          result_valid <= 1'b0;
        end
        A_L: begin
          op_a         <= sw[7:0];
          op_b         <= sw[15:8];
          result_valid <= 1'b0;
        end
        A_R: begin
          result       <= '0;
          result_valid <= 1'b0;
        end
        default: ;
      endcase
      if (state == S_WAIT) begin
        if (op_done) begin
          result       <= op_result;
          result_valid <= 1'b1;
        end else if (timeout) begin
          result_valid <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_exer2_op_sequencer.sv
// Scoreboard bench for exer2_op_sequencer: expected results are queued when C is pressed
// and popped when the sequencer leaves its busy phase.
`timescale 1ns/1ps
module tb_exer2_op_sequencer;

`ifdef CTRL_TIMEOUT_EN
  localparam int TO_CYC = 16;
`else
  localparam int TO_CYC = 1024;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [4:0]  btn = '0;
  logic [15:0] sw = '0;
  logic        op_done = 1'b0;
  logic [15:0] op_result = '0;
  logic [2:0]  test_sel;
  logic [7:0]  op_a, op_b;
  logic        op_start, result_valid, busy, err;
  logic [15:0] result;

  int n_cmp = 0;
  int n_err = 0;
  int start_cnt = 0;
  int done_cnt = 0;
  int dp_delay = 3;
  bit dp_en = 1'b1;
  bit busy_q = 1'b0;
  logic [15:0] exp_q[$];
  logic [2:0]  exp_sel;

  exer2_op_sequencer #(.TIMEOUT_CYCLES(TO_CYC), .TEST_INIT(0)) dut (
    .clk(clk), .rst_n(rst_n), .btn(btn), .sw(sw), .op_done(op_done),
    .op_result(op_result), .test_sel(test_sel), .op_a(op_a), .op_b(op_b),
    .op_start(op_start), .result(result), .result_valid(result_valid),
    .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (op_start) start_cnt <= start_cnt + 1;

  always @(negedge clk) begin
    if (busy_q && !busy) done_cnt <= done_cnt + 1;
    busy_q <= busy;
  end

  function automatic logic [15:0] calc(input logic [2:0] sel, input logic [7:0] a,
                                       input logic [7:0] b);
    logic [15:0] r;
    logic        run;
    r = '0;
    run = 1'b1;
    case (sel)
      3'd0: for (int i = 7; i >= 0; i--) begin
              if (run && a[i]) r = r + 16'd1;
              else run = 1'b0;
            end
      3'd1: for (int i = 0; i < 8; i++) r = r + 16'(a[i]);
      3'd2: r = 16'({1'b0, a} + {1'b0, b});
      3'd3: r = 16'(9'({1'b0, a} - {1'b0, b}));
      default: r = 16'(a) * 16'(b);
    endcase
    return r;
  endfunction

  // Datapath model: answers op_start after dp_delay cycles with a one-cycle op_done.
  initial begin
    logic [2:0] s;
    logic [7:0] a, b;
    forever begin
      @(posedge clk); #1;
      if (op_start && dp_en) begin
        s = test_sel; a = op_a; b = op_b;
        repeat (dp_delay) @(posedge clk);
        #1 op_done = 1'b1; op_result = calc(s, a, b);
        @(posedge clk);
        #1 op_done = 1'b0; op_result = '0;
      end
    end
  end

  task automatic press(input logic [4:0] mask, input int hold);
    @(posedge clk); #1 btn = mask;
    repeat (hold) @(posedge clk);
    #1 btn = '0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic sel_up;
    press(5'b01000, 3);
    exp_sel = (exp_sel == 3'd4) ? 3'd0 : exp_sel + 3'd1;
  endtask

  task automatic sel_down;
    press(5'b00100, 3);
    exp_sel = (exp_sel == 3'd0) ? 3'd4 : exp_sel - 3'd1;
  endtask

  task automatic wait_done(input int n0, input int budget, input string name);
    int k;
    for (k = 0; k < budget; k++) begin
      @(negedge clk);
      if (done_cnt != n0) break;
    end
    n_cmp++;
    if (k == budget) begin
      n_err++;
      $display("FAIL %s: no completion within %0d cycles (busy=%b)", name, budget, busy);
    end
  endtask

  task automatic check_result(input string name);
    logic [15:0] e;
    e = exp_q.pop_front();
    n_cmp++;
    if (result !== e || result_valid !== 1'b1 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL %s: result=%h valid=%b busy=%b, required result=%h valid=1 busy=0",
               name, result, result_valid, busy, e);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    exp_sel = 3'd0;
    @(negedge clk);
    n_cmp++;
    if ({test_sel, op_a, op_b, op_start, result, result_valid, busy, err} !== '0) begin
      n_err++;
      $display("FAIL reset: sel=%0d a=%h b=%h start=%b res=%h v=%b busy=%b err=%b, required all 0",
               test_sel, op_a, op_b, op_start, result, result_valid, busy, err);
    end
  endtask

  task automatic test_select;
    for (int i = 0; i < 5; i++) begin
      sel_up();
      n_cmp++;
      if (test_sel !== exp_sel) begin
        n_err++;
        $display("FAIL select_up%0d: test_sel=%0d required %0d", i, test_sel, exp_sel);
      end
    end
    sel_down();
    n_cmp++;
    if (test_sel !== exp_sel) begin
      n_err++;
      $display("FAIL select_down_wrap: test_sel=%0d required %0d", test_sel, exp_sel);
    end
  endtask

  task automatic test_add;
    int s0, n0;
    sw = 16'h0703;
    press(5'b00010, 3);
    n_cmp++;
    if (op_a !== 8'h03 || op_b !== 8'h07) begin
      n_err++;
      $display("FAIL load_operands: a=%h b=%h required a=03 b=07", op_a, op_b);
    end
    sel_down(); sel_down();
    n_cmp++;
    if (test_sel !== 3'd2) begin
      n_err++;
      $display("FAIL select_add: test_sel=%0d required 2", test_sel);
    end
    exp_q.push_back(16'h000A);
    s0 = start_cnt; n0 = done_cnt;
    press(5'b10000, 3);
    wait_done(n0, 100, "add_done");
    check_result("add_result");
    n_cmp++;
    if (start_cnt - s0 != 1) begin
      n_err++;
      $display("FAIL add_start_pulses: got %0d required 1", start_cnt - s0);
    end
  endtask

  task automatic test_sub;
    int n0;
    sw = 16'h0503;
    press(5'b00010, 3);
    sel_up();
    exp_q.push_back(calc(3'd3, 8'h03, 8'h05));
    n0 = done_cnt;
    press(5'b10000, 3);
    wait_done(n0, 100, "sub_done");
    check_result("sub_borrow_result");
  endtask

  task automatic test_mult_held;
    int s0, n0;
    sw = 16'hFFFF;
    press(5'b00010, 3);
    sel_up();
    exp_q.push_back(16'hFE01);
    s0 = start_cnt; n0 = done_cnt;
    press(5'b10000, 50);
    wait_done(n0, 100, "mult_done");
    check_result("mult_result");
    n_cmp++;
    if (start_cnt - s0 != 1) begin
      n_err++;
      $display("FAIL held_c_single_start: got %0d required 1", start_cnt - s0);
    end
  endtask

  task automatic test_priority;
    sw = 16'h1234;
    press(5'b01010, 3);
    exp_sel = (exp_sel == 3'd4) ? 3'd0 : exp_sel + 3'd1;
    n_cmp++;
    if (test_sel !== exp_sel || op_a !== 8'hFF || op_b !== 8'hFF || result_valid !== 1'b0) begin
      n_err++;
      $display("FAIL u_beats_l: sel=%0d a=%h b=%h v=%b required sel=%0d a=ff b=ff v=0",
               test_sel, op_a, op_b, result_valid, exp_sel);
    end
  endtask

  task automatic test_busy_ignore;
    int n0;
    dp_delay = 25;
    exp_q.push_back(calc(exp_sel, 8'hFF, 8'hFF));
    n0 = done_cnt;
    press(5'b10000, 3);
    press(5'b01000, 3);
    wait_done(n0, 100, "busy_done");
    check_result("busy_leading_ones");
    n_cmp++;
    if (test_sel !== exp_sel) begin
      n_err++;
      $display("FAIL u_while_busy: test_sel=%0d required %0d", test_sel, exp_sel);
    end
    dp_delay = 3;
  endtask

  task automatic test_clear;
    press(5'b00001, 3);
    n_cmp++;
    if (result !== 16'h0 || result_valid !== 1'b0 || err !== 1'b0) begin
      n_err++;
      $display("FAIL r_clear: result=%h v=%b err=%b required 0 0 0", result, result_valid, err);
    end
  endtask

`ifdef CTRL_TIMEOUT_EN
  task automatic test_timeout;
    int n0;
    logic [15:0] keep;
    keep = 16'h000A;
    exp_q.push_back(keep);
    sw = 16'h0703; press(5'b00010, 3);
    while (exp_sel != 3'd2) sel_up();
    n0 = done_cnt;
    press(5'b10000, 3);
    wait_done(n0, 100, "setup_done");
    check_result("setup_result");
    dp_en = 1'b0;
    n0 = done_cnt;
    press(5'b10000, 3);
    wait_done(n0, TO_CYC + 20, "timeout_exit");
    n_cmp++;
    if (err !== 1'b1 || result_valid !== 1'b0 || result !== keep || busy !== 1'b0) begin
      n_err++;
      $display("FAIL timeout: err=%b v=%b result=%h busy=%b required err=1 v=0 result=%h busy=0",
               err, result_valid, result, busy, keep);
    end
    press(5'b00001, 3);
    n_cmp++;
    if (err !== 1'b0) begin
      n_err++;
      $display("FAIL timeout_r_clear: err=%b required 0", err);
    end
    dp_en = 1'b1;
  endtask
`endif

  task automatic test_reset_mid_op;
    dp_en = 1'b0;
    press(5'b10000, 3);
    n_cmp++;
    if (busy !== 1'b1) begin
      n_err++;
      $display("FAIL mid_op_busy: busy=%b required 1", busy);
    end
    #1 rst_n = 1'b0;
    #2;
    n_cmp++;
    if (busy !== 1'b0 || op_start !== 1'b0 || test_sel !== 3'd0 || result_valid !== 1'b0) begin
      n_err++;
      $display("FAIL async_reset: busy=%b start=%b sel=%0d v=%b required 0 0 0 0",
               busy, op_start, test_sel, result_valid);
    end
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1 op_done = 1'b1; op_result = 16'hBEEF;
    repeat (2) @(posedge clk);
    #1 op_done = 1'b0; op_result = '0;
    @(negedge clk);
    n_cmp++;
    if (result !== 16'h0 || result_valid !== 1'b0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL late_op_done: result=%h v=%b busy=%b required 0 0 0",
               result, result_valid, busy);
    end
    dp_en = 1'b1;
  endtask

  initial begin
    test_reset();
    test_select();
    test_add();
    test_sub();
    test_mult_held();
    test_priority();
    test_busy_ignore();
    test_clear();
`ifdef CTRL_TIMEOUT_EN
    test_timeout();
`endif
    test_reset_mid_op();
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
